sc_rr_crossbar_port_sched: RTL and testbench
============================================

# sc_rr_crossbar_port_sched

Transaction-level round-robin scheduler for one slave port of the round-robin crossbar. It shares a single slave among NUM_MS masters and holds each grant for a whole transaction until the slave acknowledges. A watchdog releases the grant if the slave never responds. It drives the per-master enables that steer the crossbar mux for that port.

## Interface
- NUM_MS, 4: number of masters sharing the port (2..16).
- ID_W, 2: width of o_ms_id; must equal ceil(log2(NUM_MS)).
- TMO_EN, 1: 1 enables the grant watchdog; 0 means grants end only on ack or request withdrawal.
- TMO_W, 8: watchdog counter width; TMO_MAX = 2^TMO_W - 1.
- i_clk  in  1  single clock; all state on the rising edge.
- i_resetb  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided upstream.
- i_ms_req  in  NUM_MS  per-master request level; held high until the master sees its ack.
- i_sl_ack  in  1  slave completes the granted transaction; single-cycle pulse.
- o_ms_en  out  NUM_MS  registered one-hot grant, or all zero when idle.
- o_ms_id  out  ID_W  registered index of the granted master; holds its last value when idle.
- o_sl_req  out  1  registered; high while any grant is active (= |o_ms_en).
- o_tmo  out  1  registered one-cycle pulse when the watchdog aborts a grant.

## Operation
- State: FSM {IDLE, GRANT}, priority pointer ptr (ID_W bits), watchdog counter cnt (TMO_W bits).
- Arbitration function: pick the first requesting master at index ptr, ptr+1, … NUM_MS-1, 0, … ptr-1. The index wraps modulo NUM_MS, not 2^ID_W.
- IDLE:
  - If i_ms_req != 0, the next state is GRANT with the arbitrated master; o_ms_en, o_ms_id, o_sl_req update and cnt=0.
  - Otherwise the block stays in IDLE and all enables stay zero.
- GRANT, granted master g:
  - i_sl_ack=1:
    - Set ptr=(g+1) mod NUM_MS.
    - Arbitrate over i_ms_req with bit g masked and ptr already updated.
    - If a winner exists, stay in GRANT with the new grant and cnt=0 (back-to-back, no idle cycle). Otherwise go to IDLE.
  - i_sl_ack=0 and i_ms_req[g]=0 (withdrawal): ptr=(g+1) mod NUM_MS, go to IDLE, no o_tmo.
  - i_sl_ack=0, TMO_EN=1 and cnt==TMO_MAX: ptr=(g+1) mod NUM_MS, go to IDLE, pulse o_tmo=1 for the next cycle.
  - Otherwise hold the grant and increment cnt. cnt saturates at TMO_MAX when TMO_EN=0.
- Simultaneous events:
  - Ack beats timeout: no o_tmo.
  - Ack beats withdrawal: the pointer advances once.
  - New requests arriving during GRANT never preempt the current grant.
- i_sl_ack in IDLE is ignored.
- Requests for index ≥ NUM_MS do not exist; all NUM_MS request bits are valid.
- Reset (any time, including mid-grant): o_ms_en=0, o_ms_id=0, o_sl_req=0, o_tmo=0, ptr=0, cnt=0, state=IDLE. Outputs clear asynchronously on the falling edge of i_resetb.

## Timing
- Grant latency: a request sampled at edge t in IDLE produces a grant visible after edge t, i.e. one cycle.
- Release: ack sampled at edge t clears or replaces the grant after edge t. A master must drop i_ms_req in the cycle after its ack, or it will be regranted only after the other requesters have been served.
- Back-to-back: under continuous requests, one grant per ack with zero idle cycles between grants.
- Watchdog: a grant with no ack stays visible for TMO_MAX+1 cycles (cnt 0..TMO_MAX). The next cycle shows o_ms_en=0 and o_tmo=1.
- o_tmo is high for exactly one cycle per abort.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert i_resetb=0 mid-grant with o_ms_en=0010 -> o_ms_en=0000, o_sl_req=0, o_tmo=0 immediately. After release, i_ms_req=1111 -> first grant is 0001 (ptr=0).
- Single master: i_ms_req=0100 at cycle 0 -> o_ms_en=0100, o_ms_id=2, o_sl_req=1 from cycle 1. i_sl_ack at cycle 3 -> o_ms_en=0000 from cycle 4, ptr=3.
- Fairness: i_ms_req=1111 held, ack every second cycle of each grant -> grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycle between grants.
- Wrap and mask: after master 3 is acked (ptr=0) with i_ms_req=1001 still high that cycle -> next grant is 0001, not 1000. A following ack with i_ms_req=1000 -> grant 1000.
- Watchdog (TMO_W=3): grant 0010 with no ack -> grant visible 8 cycles, then o_ms_en=0000 and o_tmo=1 for one cycle, ptr=2. Repeat with ack at the 8th grant cycle -> o_tmo stays 0.
- Withdrawal: grant 0100, i_ms_req drops to 0000 with no ack -> o_ms_en=0000 next cycle, o_tmo=0, ptr=3. An ack pulse while IDLE -> no output change.

Source files
------------

// File: rtl/sc_rr_crossbar_port_sched.sv
// -----------------------------------------------------------------------------
// sc_rr_crossbar_port_sched
//
// Round-robin scheduler for one slave port of the crossbar. A grant is held
// for a whole transaction and ends in one of three ways:
//   - the slave acks it,
//   - the granted master withdraws its request, or
//   - the watchdog expires.
// On an ack the next requester (in rotating priority order) is granted in the
// same edge, so there is no idle cycle between grants.
//
// Handshake: a master raises i_ms_req and keeps it high until it sees its
// grant acked. The slave pulses i_sl_ack for one cycle to close the granted
// transaction. i_sl_ack is ignored while no grant is active.
//
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_resetb     asynchronous active-low reset
//   i_ms_req     per-master request levels
//   i_sl_ack     slave transaction-complete pulse
//   o_ms_en      registered one-hot grant (all zero when idle)
//   o_ms_id      registered index of the granted master (holds when idle)
//   o_sl_req     registered, high while a grant is active
//   o_tmo        registered one-cycle pulse when the watchdog aborts a grant
//   o_dbg_state  current FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------
module sc_rr_crossbar_port_sched #(
  parameter int NUM_MS = 4,
  parameter int ID_W   = 2,
  parameter int TMO_EN = 1,
  parameter int TMO_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_resetb,
  input  logic [NUM_MS-1:0] i_ms_req,
  input  logic              i_sl_ack,
  output logic [NUM_MS-1:0] o_ms_en,
  output logic [ID_W-1:0]   o_ms_id,
  output logic              o_sl_req,
  output logic              o_tmo,
  output logic              o_dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [TMO_W-1:0]  TMO_MAX = '1;
  localparam logic [NUM_MS-1:0] BIT0    = {{(NUM_MS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [NUM_MS-1:0]   en_q, en_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                sl_req_q, sl_req_d;
  logic                tmo_q, tmo_d;

  logic [NUM_MS-1:0]   g_mask;
  logic [ID_W-1:0]     ptr_adv;
  logic [ID_W:0]       arb_idle;
  logic [ID_W:0]       arb_ack;

  // Index after g, wrapping at NUM_MS rather than 2^ID_W.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] g);
    if (int'(g) >= NUM_MS - 1) return '0;
    return ID_W'(int'(g) + 1);
  endfunction

  // Returns {found, index} of the first request at p, p+1, ... (mod NUM_MS).
  // Scanning from the far end lets the nearest requester overwrite the result.
  function automatic logic [ID_W:0] arb(input logic [NUM_MS-1:0] req,
                                        input logic [ID_W-1:0]   p);
    logic [ID_W:0]     res;
    logic [NUM_MS-1:0] sh;
    int                idx;
    res = '0;
    for (int k = NUM_MS - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_MS) idx = idx - NUM_MS;
      sh = req >> idx;
      if (sh[0]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  assign g_mask   = BIT0 << id_q;
  assign ptr_adv  = next_idx(id_q);
  assign arb_idle = arb(i_ms_req, ptr_q);
  // On ack the just-served master is excluded and priority starts after it.
  assign arb_ack  = arb(i_ms_req & ~g_mask, ptr_adv);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    id_d    = id_q;
    tmo_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        en_d = '0;
        if (arb_idle[ID_W]) begin
          state_d = ST_GRANT;
          id_d    = arb_idle[ID_W-1:0];
          en_d    = BIT0 << arb_idle[ID_W-1:0];
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (i_sl_ack) begin
          // Ack takes precedence over both withdrawal and timeout.
          ptr_d = ptr_adv;
          if (arb_ack[ID_W]) begin
            id_d  = arb_ack[ID_W-1:0];
            en_d  = BIT0 << arb_ack[ID_W-1:0];
            cnt_d = '0;
          end else begin
            en_d    = '0;
            state_d = ST_IDLE;
          end
        end else if ((i_ms_req & g_mask) == '0) begin
          ptr_d   = ptr_adv;
          en_d    = '0;
          state_d = ST_IDLE;
        end else if ((TMO_EN != 0) && (cnt_q == TMO_MAX)) begin
          ptr_d   = ptr_adv;
          en_d    = '0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != TMO_MAX) begin
          // Saturates when the watchdog is disabled.
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = '0;
      end
    endcase

    sl_req_d = |en_d;
  end

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      en_q     <= '0;
      id_q     <= '0;
      sl_req_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      id_q     <= id_d;
      sl_req_q <= sl_req_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_ms_en     = en_q;
  assign o_ms_id     = id_q;
  assign o_sl_req    = sl_req_q;
  assign o_tmo       = tmo_q;
  assign o_dbg_state = (state_q == ST_GRANT);

endmodule

// File: tb/tb_sc_rr_crossbar_port_sched.sv
// -----------------------------------------------------------------------------
// Bench for sc_rr_crossbar_port_sched (NUM_MS=4, TMO_W=3 so TMO_MAX=7).
// A transaction-level reference model (owner, priority pointer, grant age)
// is advanced on every rising edge with the inputs that edge sampled, and all
// outputs are compared 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_sc_rr_crossbar_port_sched;

  localparam int NUM_MS  = 4;
  localparam int ID_W    = 2;
  localparam int TMO_W   = 3;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              i_resetb;
  logic [NUM_MS-1:0] i_ms_req;
  logic              i_sl_ack;
  logic [NUM_MS-1:0] o_ms_en;
  logic [ID_W-1:0]   o_ms_id;
  logic              o_sl_req;
  logic              o_tmo;
  logic              o_dbg_state;

  always #5 clk = ~clk;

  sc_rr_crossbar_port_sched #(
    .NUM_MS (NUM_MS),
    .ID_W   (ID_W),
    .TMO_EN (1),
    .TMO_W  (TMO_W)
  ) dut (
    .i_clk       (clk),
    .i_resetb    (i_resetb),
    .i_ms_req    (i_ms_req),
    .i_sl_ack    (i_sl_ack),
    .o_ms_en     (o_ms_en),
    .o_ms_id     (o_ms_id),
    .o_sl_req    (o_sl_req),
    .o_tmo       (o_tmo),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- reference model ----------------
  bit m_busy;   // a transaction currently owns the port
  int m_owner;  // current (or last) owner index
  int m_ptr;    // master with highest priority for the next decision
  int m_age;    // cycles the current grant has already been visible, minus 1
  bit m_tmo;

  int n_vec  = 0;
  int n_miss = 0;

  function automatic int pick(input logic [NUM_MS-1:0] req, input int p);
    for (int k = 0; k < NUM_MS; k++)
      if (req[(p + k) % NUM_MS]) return (p + k) % NUM_MS;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_tmo = 0;
  endtask

  task automatic model_edge(input logic [NUM_MS-1:0] req, input logic ack);
    int w;
    logic [NUM_MS-1:0] others;
    m_tmo = 0;
    if (!m_busy) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_busy = 1; m_owner = w; m_age = 0; end
    end else if (ack) begin
      m_ptr  = (m_owner + 1) % NUM_MS;
      others = req;
      others[m_owner] = 1'b0;
      w = pick(others, m_ptr);
      if (w >= 0) begin m_owner = w; m_age = 0; end
      else m_busy = 0;
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % NUM_MS; m_busy = 0;
    end else if (m_age == TMO_MAX) begin
      m_ptr = (m_owner + 1) % NUM_MS; m_busy = 0; m_tmo = 1;
    end else begin
      m_age++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [NUM_MS-1:0] e;
    e = '0;
    if (m_busy) e[m_owner] = 1'b1;
    chk("ms_en",  32'(o_ms_en),     32'(e));
    chk("ms_id",  32'(o_ms_id),     32'(m_owner));
    chk("sl_req", 32'(o_sl_req),    32'(m_busy));
    chk("tmo",    32'(o_tmo),       32'(m_tmo));
    chk("state",  32'(o_dbg_state), 32'(m_busy));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [NUM_MS-1:0] req, input logic ack);
    i_ms_req = req;
    i_sl_ack = ack;
    @(posedge clk);
    model_edge(req, ack);
    #1;
    check_model();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [NUM_MS-1:0] rreq;
    i_resetb = 1'b0;
    i_ms_req = '0;
    i_sl_ack = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_model();
    i_resetb = 1'b1;

    // Single master: grant from the next edge, release on ack, ptr -> 3.
    step(4'b0100, 1'b0);
    chk("single_grant", 32'(o_ms_en), 32'h4);
    chk("single_id",    32'(o_ms_id), 32'd2);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    chk("single_release", 32'(o_ms_en), 32'h0);
    step(4'b0000, 1'b0);

    // Fairness from ptr=3: 1000, 0001, 0010, 0100, 1000 with no idle gap.
    step(4'b1111, 1'b0);
    chk("fair_0", 32'(o_ms_en), 32'h8);
    step(4'b1111, 1'b1);
    chk("fair_1", 32'(o_ms_en), 32'h1);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    chk("fair_2", 32'(o_ms_en), 32'h2);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    chk("fair_3", 32'(o_ms_en), 32'h4);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    chk("fair_4", 32'(o_ms_en), 32'h8);
    step(4'b1111, 1'b0);

    // Wrap and mask: master 3 acked with 1001 still high -> 0001.
    step(4'b1001, 1'b1);
    chk("wrap_mask", 32'(o_ms_en), 32'h1);
    step(4'b1000, 1'b1);
    chk("wrap_next", 32'(o_ms_en), 32'h8);
    step(4'b0000, 1'b1);
    chk("wrap_idle", 32'(o_sl_req), 32'h0);

    // Watchdog: 8 visible grant cycles, then one-cycle o_tmo, ptr -> 2.
    for (int i = 0; i < TMO_MAX + 1; i++) step(4'b0010, 1'b0);
    chk("wd_last_grant", 32'(o_ms_en), 32'h2);
    step(4'b0010, 1'b0);
    chk("wd_abort_en",  32'(o_ms_en), 32'h0);
    chk("wd_abort_tmo", 32'(o_tmo),   32'h1);
    step(4'b0000, 1'b0);
    chk("wd_tmo_pulse", 32'(o_tmo), 32'h0);
    // Same again but acked on the 8th grant cycle: ack wins, no o_tmo.
    for (int i = 0; i < TMO_MAX + 1; i++) step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    chk("wd_ack_tmo", 32'(o_tmo),   32'h0);
    chk("wd_ack_en",  32'(o_ms_en), 32'h0);
    step(4'b0000, 1'b0);

    // Withdrawal from ptr=2: grant 0100, drop request -> idle, ptr -> 3.
    step(4'b0100, 1'b0);
    chk("wd_grant", 32'(o_ms_en), 32'h4);
    step(4'b0000, 1'b0);
    chk("withdraw_en",  32'(o_ms_en), 32'h0);
    chk("withdraw_tmo", 32'(o_tmo),   32'h0);
    step(4'b0000, 1'b1);
    chk("idle_ack_en", 32'(o_ms_en), 32'h0);
    chk("idle_ack_id", 32'(o_ms_id), 32'd2);
    step(4'b1111, 1'b0);
    chk("withdraw_ptr", 32'(o_ms_en), 32'h8);

    // Asynchronous reset mid-grant with 0010, then first grant from ptr=0.
    step(4'b0010, 1'b1);
    chk("pre_reset_en", 32'(o_ms_en), 32'h2);
    i_resetb = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk); #1;
    check_model();
    i_resetb = 1'b1;
    step(4'b1111, 1'b0);
    chk("post_reset_first", 32'(o_ms_en), 32'h1);

    // Randomised traffic: requests change occasionally, acks are sparse
    // enough that the watchdog still fires now and then.
    rreq = 4'b1111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rreq = 4'($urandom_range(0, 15));
      step(rreq, 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
